msk_hpc3_and_sched: RTL and testbench

Round-robin scheduler that time-shares one HPC3 cross-domain masked AND gadget (latency 1, `d` shares) between `N` requesters. It arbitrates requests, drives the gadget operand and randomness ports, and gates issue on a valid/ready handshake with the PRNG. It also provides the gadget's one-cycle-delayed `a` sharing (`ina_prev`) and returns each result tagged with the requester index. It sits between the masked S-box/datapath controllers and a single instantiated gadget.

---
 rtl/msk_hpc3_and_sched.sv | 117 +++++++++++
 tb/tb_msk_hpc3_and_sched.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/msk_hpc3_and_sched.sv
// Round-robin scheduler sharing one HPC3 masked AND gadget among N requesters.
// Optional MSK_SCHED_ZEROIZE_EN: zero gadget operands/randomness when idle.
module msk_hpc3_and_sched #(
    parameter int d     = 2,
    parameter int N     = 4,
    parameter int RND_W = d * (d - 1),
    parameter int IDW   = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req_valid,
    output logic [N-1:0]     req_ready,
    input  logic [N*d-1:0]   req_a,
    input  logic [N*d-1:0]   req_b,
    input  logic             rnd_valid,
    output logic             rnd_ready,
    input  logic [RND_W-1:0] rnd_in,
    output logic [d-1:0]     g_ina,
    output logic [d-1:0]     g_inb,
    output logic [RND_W-1:0] g_rnd,
    output logic [d-1:0]     g_ina_prev,
    input  logic [d-1:0]     g_out,
    output logic             res_valid,
    output logic [IDW-1:0]   res_id,
    output logic [d-1:0]     res_out
);

    logic [IDW-1:0] ptr;
    logic [IDW-1:0] ptr_nxt;
    logic [IDW-1:0] grant_id;
    logic [IDW-1:0] sel_id;
    logic [IDW-1:0] s1_id;
    logic           s1_v;
    logic [d-1:0]   prev_a;
    logic           found;
    logic           issue;
    logic [d-1:0]   a_sel;
    logic [d-1:0]   b_sel;
    int             idx;

    // Search N slots starting at ptr; the first valid one wins.
    always_comb begin
        grant_id = '0;
        found    = 1'b0;
        idx      = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (!found && req_valid[idx]) begin
                found    = 1'b1;
                grant_id = IDW'(idx);
            end
        end
    end

    assign issue = !rst && rnd_valid && found;

    always_comb begin
        ptr_nxt = ptr;
        if (issue) begin
            if (grant_id == IDW'(N - 1)) begin
                ptr_nxt = '0;
            end else begin
                ptr_nxt = grant_id + IDW'(1);
            end
        end
    end

    // Idle cycles keep steering the last granted requester onto the gadget.
    assign sel_id = issue ? grant_id : s1_id;
    assign a_sel  = req_a[int'(sel_id) * d +: d];
    assign b_sel  = req_b[int'(sel_id) * d +: d];

    always_comb begin
        req_ready = '0;
        if (issue) begin
            req_ready = N'(1) << grant_id;
        end
        rnd_ready = issue;
`ifdef MSK_SCHED_ZEROIZE_EN
        g_ina = issue ? a_sel : '0;
        g_inb = issue ? b_sel : '0;
        g_rnd = issue ? rnd_in : '0;
`else
        g_ina = a_sel;
        g_inb = b_sel;
        g_rnd = rnd_in;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr    <= '0;
            s1_v   <= 1'b0;
            s1_id  <= '0;
            prev_a <= '0;
        end else begin
            ptr  <= ptr_nxt;
            s1_v <= issue;
            if (issue) begin
                s1_id  <= grant_id;
                prev_a <= g_ina;
            end else begin
`ifdef MSK_SCHED_ZEROIZE_EN
                prev_a <= '0;
`else
                prev_a <= prev_a;
`endif
            end
        end
    end

    assign g_ina_prev = prev_a;
    assign res_valid  = s1_v;
    assign res_id     = s1_id;
    assign res_out    = g_out;

endmodule

// File: tb/tb_msk_hpc3_and_sched.sv
// Self-checking bench for msk_hpc3_and_sched with a behavioural gadget
// and a queue-free reference model of arbitration and result return.
module tb_msk_hpc3_and_sched;

    localparam int D = 2;
    localparam int N = 4;
    localparam int RW = D * (D - 1);
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_ready;
    logic [N*D-1:0] req_a;
    logic [N*D-1:0] req_b;
    logic          rnd_valid;
    logic          rnd_ready;
    logic [RW-1:0] rnd_in;
    logic [D-1:0]  g_ina;
    logic [D-1:0]  g_inb;
    logic [RW-1:0] g_rnd;
    logic [D-1:0]  g_ina_prev;
    logic [D-1:0]  g_out;
    logic          res_valid;
    logic [IW-1:0] res_id;
    logic [D-1:0]  res_out;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int          m_ptr;
    int          m_last;
    logic        m_res_v;
    int          m_res_id;
    logic        m_res_bit;
    logic [D-1:0] m_prev;

    msk_hpc3_and_sched #(.d(D), .N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .rnd_valid  (rnd_valid),
        .rnd_ready  (rnd_ready),
        .rnd_in     (rnd_in),
        .g_ina      (g_ina),
        .g_inb      (g_inb),
        .g_rnd      (g_rnd),
        .g_ina_prev (g_ina_prev),
        .g_out      (g_out),
        .res_valid  (res_valid),
        .res_id     (res_id),
        .res_out    (res_out)
    );

    always #5 clk = ~clk;

    // Behavioural gadget: latency 1, fresh random re-sharing of (^a)&(^b)
    logic gmask = 1'b0;
    always @(negedge clk) gmask <= 1'($urandom);
    always @(posedge clk) begin
        g_out[0] <= gmask;
        g_out[1] <= gmask ^ ((^g_ina) & (^g_inb));
    end

    function automatic int find_grant(input logic [N-1:0] rv);
        for (int i = 0; i < N; i++) begin
            if (rv[(m_ptr + i) % N]) return (m_ptr + i) % N;
        end
        return -1;
    endfunction

    function automatic void model_reset();
        m_ptr = 0;
        m_last = 0;
        m_res_v = 1'b0;
        m_res_id = 0;
        m_res_bit = 1'b0;
        m_prev = '0;
    endfunction

    function automatic void model_commit(input logic iss, input int k);
        m_res_v = iss;
        if (iss) begin
            m_res_id = k;
            m_res_bit = (^req_a[k*D +: D]) & (^req_b[k*D +: D]);
            m_prev = req_a[k*D +: D];
            m_ptr = (k + 1) % N;
            m_last = k;
        end else begin
`ifdef MSK_SCHED_ZEROIZE_EN
            m_prev = '0;
`endif
        end
    endfunction

    task automatic drive(input logic [N-1:0] rv, input logic [N*D-1:0] a,
                         input logic [N*D-1:0] b, input logic rv_rnd,
                         input logic [RW-1:0] rnd);
        @(negedge clk);
        req_valid = rv;
        req_a = a;
        req_b = b;
        rnd_valid = rv_rnd;
        rnd_in = rnd;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(4'b1111, 8'($urandom), 8'($urandom), 1'b1, 2'($urandom));
        model_reset();
        n_checks++;
        if (req_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_req_ready got %b want 0000", req_ready);
        end
        n_checks++;
        if (rnd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_rnd_ready got %b want 0", rnd_ready);
        end
        n_checks++;
        if (res_valid !== 1'b0 || res_id !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_res got v=%b id=%0d want v=0 id=0", res_valid, res_id);
        end
        n_checks++;
        if (g_ina_prev !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_ina_prev got %b want 00", g_ina_prev);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single();
        drive(4'b0001, 8'h01, 8'h03, 1'b1, 2'b10);
        n_checks++;
        if (req_ready !== 4'b0001 || rnd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL single_grant got rdy=%b rnd_rdy=%b want 0001/1", req_ready, rnd_ready);
        end
        n_checks++;
        if (g_ina !== 2'b01 || g_inb !== 2'b11 || g_rnd !== 2'b10) begin
            n_fail++;
            $display("FAIL single_operands got a=%b b=%b r=%b want 01/11/10", g_ina, g_inb, g_rnd);
        end
        model_commit(1'b1, 0);
        drive(4'b0000, 8'h02, 8'h01, 1'b1, 2'b11);
        n_checks++;
        if (g_ina_prev !== 2'b01) begin
            n_fail++;
            $display("FAIL single_ina_prev got %b want 01", g_ina_prev);
        end
        n_checks++;
        if (res_valid !== 1'b1 || res_id !== 2'd0 || (^res_out) !== 1'b0) begin
            n_fail++;
            $display("FAIL single_result got v=%b id=%0d x=%b want 1/0/0", res_valid, res_id, ^res_out);
        end
        n_checks++;
`ifdef MSK_SCHED_ZEROIZE_EN
        if (g_ina !== 2'b00 || g_inb !== 2'b00 || g_rnd !== 2'b00) begin
            n_fail++;
            $display("FAIL idle_zeroize got a=%b b=%b r=%b want 00", g_ina, g_inb, g_rnd);
        end
`else
        if (g_ina !== 2'b10 || g_inb !== 2'b01 || g_rnd !== 2'b11) begin
            n_fail++;
            $display("FAIL idle_track got a=%b b=%b r=%b want 10/01/11", g_ina, g_inb, g_rnd);
        end
`endif
        model_commit(1'b0, 0);
        drive(4'b0000, 8'h02, 8'h01, 1'b0, 2'b00);
        n_checks++;
`ifdef MSK_SCHED_ZEROIZE_EN
        if (g_ina_prev !== 2'b00) begin
            n_fail++;
            $display("FAIL idle_prev_zero got %b want 00", g_ina_prev);
        end
`else
        if (g_ina_prev !== 2'b01) begin
            n_fail++;
            $display("FAIL idle_prev_hold got %b want 01", g_ina_prev);
        end
`endif
        n_checks++;
        if (res_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_pulse got res_valid=%b want 0", res_valid);
        end
        model_commit(1'b0, 0);
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp_rdy;
        int order[5] = '{0, 1, 2, 3, 0};
        int prev_k;
        rst = 1'b1;
        #1;
        rst = 1'b0;
        model_reset();
        prev_k = -1;
        for (int c = 0; c < 6; c++) begin
            drive(c < 5 ? 4'b1111 : 4'b0000, 8'($urandom), 8'($urandom), 1'b1, 2'($urandom));
            if (c < 5) begin
                exp_rdy = 4'(1 << order[c]);
                n_checks++;
                if (req_ready !== exp_rdy) begin
                    n_fail++;
                    $display("FAIL rr_grant%0d got %b want %b", c, req_ready, exp_rdy);
                end
            end
            if (prev_k >= 0) begin
                n_checks++;
                if (res_valid !== 1'b1 || res_id !== 2'(prev_k)) begin
                    n_fail++;
                    $display("FAIL rr_res%0d got v=%b id=%0d want 1/%0d", c, res_valid, res_id, prev_k);
                end
            end
            if (c < 5) begin
                model_commit(1'b1, order[c]);
                prev_k = order[c];
            end else begin
                model_commit(1'b0, 0);
            end
        end
    endtask

    task automatic test_stall();
        for (int c = 0; c < 3; c++) begin
            drive(4'b0110, 8'($urandom), 8'($urandom), 1'b0, 2'($urandom));
            n_checks++;
            if (req_ready !== 4'b0000 || rnd_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL stall%0d got rdy=%b rnd_rdy=%b want 0000/0", c, req_ready, rnd_ready);
            end
            n_checks++;
            if (res_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_res%0d got %b want 0", c, res_valid);
            end
            model_commit(1'b0, 0);
        end
        drive(4'b0110, 8'($urandom), 8'($urandom), 1'b1, 2'($urandom));
        n_checks++;
        if (req_ready !== 4'b0010 || rnd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_resume got rdy=%b rnd_rdy=%b want 0010/1", req_ready, rnd_ready);
        end
        model_commit(1'b1, 1);
    endtask

    task automatic test_random_soak();
        logic [N-1:0]   rv;
        logic [N-1:0]   exp_rdy;
        logic [N*D-1:0] a;
        logic [N*D-1:0] b;
        logic [N-1:0]   pend;
        logic           rndv;
        logic           iss;
        int             k;
        int             ops;
        int             waited[N];
        pend = '0;
        a = req_a;
        b = req_b;
        ops = 0;
        for (int i = 0; i < N; i++) waited[i] = 0;
        for (int c = 0; c < 14000 && ops < 10000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (pend[i]) begin
                    rv[i] = 1'b1;
                end else begin
                    rv[i] = ($urandom_range(0, 2) != 0);
                    a[i*D +: D] = 2'($urandom);
                    b[i*D +: D] = 2'($urandom);
                end
            end
            rndv = ($urandom_range(0, 4) != 0);
            drive(rv, a, b, rndv, 2'($urandom));
            k = find_grant(rv);
            iss = rndv && (k >= 0);
            exp_rdy = iss ? 4'(1 << k) : 4'b0000;
            n_checks++;
            if (req_ready !== exp_rdy || rnd_ready !== iss) begin
                n_fail++;
                $display("FAIL soak_grant c%0d got %b/%b want %b/%b", c, req_ready, rnd_ready, exp_rdy, iss);
            end
            n_checks++;
            if (res_valid !== m_res_v) begin
                n_fail++;
                $display("FAIL soak_res_valid c%0d got %b want %b", c, res_valid, m_res_v);
            end else if (m_res_v) begin
                n_checks++;
                if (res_id !== 2'(m_res_id) || (^res_out) !== m_res_bit) begin
                    n_fail++;
                    $display("FAIL soak_result c%0d got id=%0d x=%b want %0d/%b", c, res_id, ^res_out, m_res_id, m_res_bit);
                end
            end
            n_checks++;
            if (g_ina_prev !== m_prev) begin
                n_fail++;
                $display("FAIL soak_ina_prev c%0d got %b want %b", c, g_ina_prev, m_prev);
            end
            if (iss) begin
                n_checks++;
                if (g_ina !== a[k*D +: D] || g_inb !== b[k*D +: D] || g_rnd !== rnd_in) begin
                    n_fail++;
                    $display("FAIL soak_operands c%0d got %b/%b/%b", c, g_ina, g_inb, g_rnd);
                end
                n_checks++;
                if (waited[k] > N - 1) begin
                    n_fail++;
                    $display("FAIL soak_starve req%0d got wait=%0d want <=%0d", k, waited[k], N - 1);
                end
                for (int i = 0; i < N; i++) begin
                    if (i == k) waited[i] = 0;
                    else if (rv[i]) waited[i]++;
                end
                ops++;
            end else begin
                n_checks++;
`ifdef MSK_SCHED_ZEROIZE_EN
                if (g_ina !== 2'b00 || g_inb !== 2'b00 || g_rnd !== 2'b00) begin
`else
                if (g_ina !== a[m_last*D +: D] || g_inb !== b[m_last*D +: D] || g_rnd !== rnd_in) begin
`endif
                    n_fail++;
                    $display("FAIL soak_idle_mux c%0d got %b/%b/%b", c, g_ina, g_inb, g_rnd);
                end
            end
            pend = rv & ~exp_rdy;
            model_commit(iss, k);
        end
        n_checks++;
        if (ops < 10000) begin
            n_fail++;
            $display("FAIL soak_ops got %0d want 10000", ops);
        end
    endtask

    task automatic test_midflight_reset();
        drive(4'b1000, 8'($urandom), 8'($urandom), 1'b1, 2'($urandom));
        @(negedge clk);
        req_valid = 4'b0000;
        #1;
        n_checks++;
        if (res_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_pre got res_valid=%b want 1", res_valid);
        end
        rst = 1'b1;
        req_valid = 4'b1111;
        #1;
        n_checks++;
        if (res_valid !== 1'b0 || res_id !== 2'd0 || g_ina_prev !== 2'b00) begin
            n_fail++;
            $display("FAIL mid_reset got v=%b id=%0d prev=%b want 0/0/00", res_valid, res_id, g_ina_prev);
        end
        n_checks++;
        if (req_ready !== 4'b0000 || rnd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_handshake got %b/%b want 0000/0", req_ready, rnd_ready);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        drive(4'b1100, 8'($urandom), 8'($urandom), 1'b1, 2'($urandom));
        n_checks++;
        if (req_ready !== 4'b0100) begin
            n_fail++;
            $display("FAIL mid_first_grant got %b want 0100", req_ready);
        end
    endtask

    initial begin
        rst = 1'b1;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        rnd_valid = 1'b0;
        rnd_in = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_stall();
        test_random_soak();
        test_midflight_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
